dust_cmd_sequencer: RTL and testbench

Reader-side command sequencer that drives the single-wire pulse link into the dust-node receiver FSM. On a start request it emits one full command frame: wake pulses, a pulse-interval-encoded amplitude word (MSB first), arm pulses, and a programmable number of scan pulses. On abort it forces the link quiet long enough for the receiver's idle timeout to return it to reset. It sits between the host/test controller and the `DATA_IN` line of the receiver.

---
 rtl/dust_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_dust_cmd_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dust_cmd_sequencer.sv
// dust_cmd_sequencer: emits one command frame on the single-wire pulse link
// (wake pulses, interval-encoded amplitude word MSB first, arm pulses, scan
// pulses). An abort forces the line quiet until the receiver has timed out.
//
// Handshake: start is a level request sampled only while idle (busy=0); it
// is not queued. abort is sampled only while a frame is running, and is
// ignored during the quiet period. done/aborted are single-cycle pulses.
//
// The state register drives combinational "this cycle" outputs, and those
// outputs are registered. DATA_OUT and busy therefore lag the state by one
// cycle, which gives the one-cycle start latency. done needs one extra
// stage so that it lands in the cycle after the last low cycle of the frame.
module dust_cmd_sequencer #(
    parameter int N_BITS    = 4,
    parameter int SHORT_GAP = 3,
    parameter int LONG_GAP  = 7,
    parameter int SEP_GAP   = 1,
    parameter int SCAN_GAP  = 4,
    parameter int TIMEOUT   = 10
) (
    input  logic              CLK_IN,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_BITS-1:0] amp,
    input  logic [7:0]        scan_count,
    output logic              DATA_OUT,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [2:0]        o_dbg_state
);

    localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int CW = 8;

    // Gap counters load (length - 1) and count down to zero.
    localparam logic [CW-1:0] C_SHORT = CW'(SHORT_GAP - 1);
    localparam logic [CW-1:0] C_LONG  = CW'(LONG_GAP - 1);
    localparam logic [CW-1:0] C_SEP   = CW'(SEP_GAP - 1);
    localparam logic [CW-1:0] C_SCAN  = CW'(SCAN_GAP - 1);
    localparam logic [CW-1:0] C_QUIET = CW'(TIMEOUT + 1);
    localparam logic [BW-1:0] C_MSB   = BW'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAKE  = 3'd1,
        S_SYM_A = 3'd2,
        S_SYM_B = 3'd3,
        S_SYM_C = 3'd4,
        S_ARM   = 3'd5,
        S_SCAN  = 3'd6,
        S_QUIET = 3'd7
    } state_t;

    state_t              r_state;
    logic                r_in_gap;
    logic [CW-1:0]       r_cnt;
    logic [7:0]          r_rep;
    logic [BW-1:0]       r_bit;
    logic [N_BITS-1:0]   r_amp;
    logic [7:0]          r_scan;
    logic                r_data;
    logic                r_busy;
    logic                r_done_pre;
    logic                r_done;
    logic                r_aborted;

    state_t              w_state_nxt;
    logic                w_in_gap_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [7:0]          w_rep_nxt;
    logic [BW-1:0]       w_bit_nxt;
    logic [N_BITS-1:0]   w_amp_nxt;
    logic [7:0]          w_scan_nxt;
    logic                w_data;
    logic                w_busy;
    logic                w_fin;
    logic                w_abt_fin;
    logic [CW-1:0]       w_gap_len;
    logic                w_cur_bit;

    assign w_cur_bit = r_amp[r_bit];

    // Select the gap that follows the pulse of the current element.
    always_comb begin
        w_gap_len = C_SEP;
        case (r_state)
            S_SYM_A: w_gap_len = w_cur_bit ? C_LONG : C_SHORT;
            S_SYM_B: w_gap_len = w_cur_bit ? C_SHORT : C_LONG;
            S_SCAN:  w_gap_len = C_SCAN;
            default: w_gap_len = C_SEP;
        endcase
    end

    // Next-state logic: each element is one pulse cycle followed by its gap.
    always_comb begin
        w_state_nxt  = r_state;
        w_in_gap_nxt = r_in_gap;
        w_cnt_nxt    = r_cnt;
        w_rep_nxt    = r_rep;
        w_bit_nxt    = r_bit;
        w_amp_nxt    = r_amp;
        w_scan_nxt   = r_scan;
        w_data       = 1'b0;
        w_busy       = (r_state != S_IDLE);
        w_fin        = 1'b0;
        w_abt_fin    = 1'b0;

        if (r_state == S_IDLE) begin
            if (start) begin
                w_state_nxt  = S_WAKE;
                w_in_gap_nxt = 1'b0;
                w_rep_nxt    = 8'd0;
                w_bit_nxt    = C_MSB;
                w_amp_nxt    = amp;
                w_scan_nxt   = scan_count;
            end
        end else if (r_state == S_QUIET) begin
            if (r_cnt == '0) begin
                w_state_nxt = S_IDLE;
                w_abt_fin   = 1'b1;
                w_busy      = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end else if (abort) begin
            // Pulse in flight is suppressed this cycle; line stays low after.
            w_state_nxt  = S_QUIET;
            w_cnt_nxt    = C_QUIET;
            w_in_gap_nxt = 1'b0;
        end else if (!r_in_gap) begin
            w_data       = 1'b1;
            w_in_gap_nxt = 1'b1;
            w_cnt_nxt    = w_gap_len;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end else begin
            w_in_gap_nxt = 1'b0;
            case (r_state)
                S_WAKE: begin
                    if (r_rep == 8'd2) begin
                        w_state_nxt = S_SYM_A;
                        w_rep_nxt   = 8'd0;
                    end else begin
                        w_rep_nxt = r_rep + 8'd1;
                    end
                end
                S_SYM_A: w_state_nxt = S_SYM_B;
                S_SYM_B: w_state_nxt = S_SYM_C;
                S_SYM_C: begin
                    if (r_bit == '0) begin
                        w_state_nxt = S_ARM;
                    end else begin
                        w_state_nxt = S_SYM_A;
                        w_bit_nxt   = r_bit - 1'b1;
                    end
                end
                S_ARM: begin
                    if (r_rep == 8'd1) begin
                        w_rep_nxt = 8'd0;
                        if (r_scan == 8'd0) begin
                            w_state_nxt = S_IDLE;
                            w_fin       = 1'b1;
                        end else begin
                            w_state_nxt = S_SCAN;
                        end
                    end else begin
                        w_rep_nxt = r_rep + 8'd1;
                    end
                end
                S_SCAN: begin
                    if (r_rep == r_scan - 8'd1) begin
                        w_state_nxt = S_IDLE;
                        w_rep_nxt   = 8'd0;
                        w_fin       = 1'b1;
                    end else begin
                        w_rep_nxt = r_rep + 8'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, counters, latches and registered outputs.
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in_gap   <= 1'b0;
            r_cnt      <= '0;
            r_rep      <= 8'd0;
            r_bit      <= '0;
            r_amp      <= '0;
            r_scan     <= 8'd0;
            r_data     <= 1'b0;
            r_busy     <= 1'b0;
            r_done_pre <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_gap   <= w_in_gap_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rep      <= w_rep_nxt;
            r_bit      <= w_bit_nxt;
            r_amp      <= w_amp_nxt;
            r_scan     <= w_scan_nxt;
            r_data     <= w_data;
            r_busy     <= w_busy;
            r_done_pre <= w_fin;
            r_done     <= r_done_pre;
            r_aborted  <= w_abt_fin;
        end
    end

    assign DATA_OUT    = r_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dust_cmd_sequencer.sv
// Bench for dust_cmd_sequencer: directed frames, abort, ignored starts,
// back-to-back frames and mid-frame reset, with inline checks per test.
module tb_dust_cmd_sequencer;

    localparam int SHORT_GAP = 3;
    localparam int LONG_GAP  = 7;
    localparam int SEP_GAP   = 1;
    localparam int SCAN_GAP  = 4;
    localparam int TIMEOUT   = 10;

    logic       CLK_IN = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] amp = 4'd0;
    logic [7:0] scan_count = 8'd0;
    logic       DATA_OUT;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    int done_at;

    dust_cmd_sequencer #(
        .N_BITS(4), .SHORT_GAP(SHORT_GAP), .LONG_GAP(LONG_GAP),
        .SEP_GAP(SEP_GAP), .SCAN_GAP(SCAN_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_IN(CLK_IN), .rst_n(rst_n), .start(start), .abort(abort),
        .amp(amp), .scan_count(scan_count), .DATA_OUT(DATA_OUT),
        .busy(busy), .done(done), .aborted(aborted), .o_dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 CLK_IN = ~CLK_IN;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // expected frame model built from the pulse/gap description
    task push_pulse(input int gap);
        exp_q.push_back(1'b1);
        repeat (gap) exp_q.push_back(1'b0);
    endtask

    task build_exp(input logic [3:0] a, input int sc);
        exp_q.delete();
        repeat (3) push_pulse(SEP_GAP);
        for (int b = 3; b >= 0; b--) begin
            if (a[b]) begin
                push_pulse(LONG_GAP);
                push_pulse(SHORT_GAP);
            end else begin
                push_pulse(SHORT_GAP);
                push_pulse(LONG_GAP);
            end
            push_pulse(SEP_GAP);
        end
        repeat (2) push_pulse(SEP_GAP);
        repeat (sc) push_pulse(SCAN_GAP);
    endtask

    // driver: request a frame, then scramble the inputs to prove latching;
    // returns at the sample point of frame cycle 0
    task kick(input logic [3:0] a, input logic [7:0] sc);
        @(negedge CLK_IN);
        amp = a;
        scan_count = sc;
        start = 1'b1;
        @(negedge CLK_IN);
        start = 1'b0;
        amp = ~a;
        scan_count = 8'hFF;
        checks++;
        if (busy !== 1'b0 || DATA_OUT !== 1'b0) begin
            errors++;
            $display("FAIL kick_latency: busy=%b data=%b, required 0/0", busy, DATA_OUT);
        end
        @(negedge CLK_IN);
    endtask

    // monitor: record the line from frame cycle 0 until done, compare to exp_q;
    // optional start pokes at cycles pa/pb (use -10 to disable)
    task record_frame(input int budget, input int pa, input int pb);
        got_q.delete();
        done_at = -1;
        for (int c = 0; c < budget; c++) begin
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            got_q.push_back(DATA_OUT);
            if (c < exp_q.size()) begin
                checks++;
                if (DATA_OUT !== exp_q[c]) begin
                    errors++;
                    $display("FAIL trace[%0d]: got %b, required %b", c, DATA_OUT, exp_q[c]);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_frame[%0d]: got %b, required 1", c, busy);
            end
            if (c == pa || c == pb) start = 1'b1;
            else if (c == pa + 1 || c == pb + 1) start = 1'b0;
            @(negedge CLK_IN);
        end
        checks++;
        if (done_at != exp_q.size()) begin
            errors++;
            $display("FAIL frame_len: done at %0d, required %0d", done_at, exp_q.size());
        end
        checks++;
        if (done_at >= 0 && busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b, required 0", busy);
        end
    endtask

    task test_reset();
        #12;
        checks++;
        if ({DATA_OUT, busy, done, aborted} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000", {DATA_OUT, busy, done, aborted});
        end
        checks++;
        if (dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, required 0", dbg_state);
        end
        @(negedge CLK_IN);
        rst_n = 1'b1;
        repeat (3) @(negedge CLK_IN);
        checks++;
        if (DATA_OUT !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: data=%b busy=%b, required 0/0", DATA_OUT, busy);
        end
    endtask

    task test_frame_1011();
        int pulses[9] = '{0, 2, 4, 6, 14, 18, 20, 24, 32};
        int pos[$];
        int run;
        int max_run;
        logic [3:0] dec;
        build_exp(4'b1011, 2);
        kick(4'b1011, 8'd2);
        record_frame(200, -10, -10);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (pulses[i] >= got_q.size() || got_q[pulses[i]] !== 1'b1) begin
                errors++;
                $display("FAIL pulse_at_%0d: not seen, required 1", pulses[i]);
            end
        end
        checks++;
        if (done_at != 76) begin
            errors++;
            $display("FAIL len_1011: got %0d, required 76", done_at);
        end
        run = 0;
        max_run = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] === 1'b1) begin
                pos.push_back(i);
                run = 0;
            end else begin
                run++;
                if (run > max_run) max_run = run;
            end
        end
        dec = 4'd0;
        if (pos.size() >= 15)
            for (int b = 0; b < 4; b++)
                dec[3-b] = ((pos[4+3*b] - pos[3+3*b] - 1) == LONG_GAP);
        checks++;
        if (dec !== 4'b1011) begin
            errors++;
            $display("FAIL decode_amp: got %b, required 1011", dec);
        end
        checks++;
        if (max_run >= TIMEOUT) begin
            errors++;
            $display("FAIL low_run: got %0d, required < %0d", max_run, TIMEOUT);
        end
    endtask

    task test_frame_0000();
        int npulse;
        build_exp(4'b0000, 0);
        kick(4'b0000, 8'd0);
        record_frame(200, -10, -10);
        checks++;
        if (done_at != 66) begin
            errors++;
            $display("FAIL len_0000: got %0d, required 66", done_at);
        end
        npulse = 0;
        foreach (got_q[i]) if (got_q[i] === 1'b1) npulse++;
        checks++;
        if (npulse != 17) begin
            errors++;
            $display("FAIL pulses_0000: got %0d, required 17", npulse);
        end
    endtask

    task test_abort();
        logic bad;
        kick(4'b1011, 8'd2);
        repeat (10) @(negedge CLK_IN);
        abort = 1'b1;
        @(negedge CLK_IN);
        abort = 1'b0;
        for (int c = 11; c <= 22; c++) begin
            checks++;
            if (DATA_OUT !== 1'b0 || busy !== 1'b1 || aborted !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL quiet[%0d]: data=%b busy=%b abt=%b done=%b, required 0100",
                         c, DATA_OUT, busy, aborted, done);
            end
            if (c == 15) abort = 1'b1;
            if (c == 16) begin
                abort = 1'b0;
                start = 1'b1;
            end
            if (c == 17) start = 1'b0;
            @(negedge CLK_IN);
        end
        checks++;
        if (aborted !== 1'b1 || busy !== 1'b0 || DATA_OUT !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL aborted_pulse: abt=%b busy=%b data=%b done=%b, required 1000",
                     aborted, busy, DATA_OUT, done);
        end
        bad = 1'b0;
        repeat (30) begin
            @(negedge CLK_IN);
            if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0 || DATA_OUT !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL after_abort: activity seen, required idle line and no done");
        end
    endtask

    task test_start_ignored();
        logic bad;
        build_exp(4'b1011, 2);
        kick(4'b1011, 8'd2);
        record_frame(200, 5, 40);
        bad = 1'b0;
        repeat (10) begin
            @(negedge CLK_IN);
            if (busy !== 1'b0 || DATA_OUT !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL extra_frame: line active after done, required idle");
        end
    endtask

    task test_back_to_back();
        build_exp(4'b1011, 2);
        @(negedge CLK_IN);
        amp = 4'b1011;
        scan_count = 8'd2;
        start = 1'b1;
        repeat (2) @(negedge CLK_IN);
        record_frame(200, -10, -10);
        @(negedge CLK_IN);
        checks++;
        if (DATA_OUT !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: data=%b busy=%b done=%b, required 110", DATA_OUT, busy, done);
        end
        start = 1'b0;
        record_frame(200, -10, -10);
        checks++;
        if (done_at != 76) begin
            errors++;
            $display("FAIL b2b_len: got %0d, required 76", done_at);
        end
    endtask

    task test_reset_mid();
        logic bad;
        kick(4'b1011, 8'd2);
        repeat (30) @(negedge CLK_IN);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({DATA_OUT, busy, done, aborted} !== 4'b0000 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: outs=%b state=%0d, required 0000/0",
                     {DATA_OUT, busy, done, aborted}, dbg_state);
        end
        @(negedge CLK_IN);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge CLK_IN);
            if (DATA_OUT !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_after_mid_reset: activity seen, required idle");
        end
    endtask

    // test sequence and final report
    initial begin
        test_reset();
        test_frame_1011();
        test_frame_0000();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_frame_1011();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
